m2_block_sequencer: RTL and testbench
=====================================

// Module: m2_block_sequencer
// PURPOSE
//  Parametrised top-level scheduler for the IDCT milestone pipeline; supersedes hard-coded block sequencing.
//  Issues start pulses to the fetch-Sp, compute-T, compute-S and write-S stages and collects their finish pulses.
//  Overlaps fetch+CS with CT+WS per block, generates write-back block coordinates for Y/U/V planes.
//  Drives a phase code that the surrounding mux logic uses for SRAM and DP-RAM port ownership.
// PARAMETERS
//  Y_W_BLK   40  Y plane width in 8x8 blocks
//  Y_H_BLK   30  Y plane height in blocks
//  C_W_BLK   20  U/V plane width in blocks
//  C_H_BLK   30  U/V plane height in blocks
//  BLK       8   block edge in pixels; col step = BLK/2 (16-bit words), row step = BLK
//  ADDR_W    10  width of col_addr/row_addr
// PORTS
//  Clock_50     in   1       system clock
//  Resetn       in   1       async active-low reset
//  start        in   1       begin full-frame decode; ignored unless busy=0
//  fetch_start  out  1       1-cycle pulse to fetch-Sp stage
//  fetch_finish in   1       1-cycle pulse from fetch-Sp stage
//  ct_start     out  1       1-cycle pulse to compute-T
//  ct_finish    in   1       1-cycle pulse from compute-T
//  cs_start     out  1       1-cycle pulse to compute-S
//  cs_finish    in   1       1-cycle pulse from compute-S
//  ws_start     out  1       1-cycle pulse to write-S
//  ws_finish    in   1       1-cycle pulse from write-S
//  phase        out  3       current state encoding (mux select)
//  col_addr     out  ADDR_W  write-back block column (words) for current write-S block
//  row_addr     out  ADDR_W  write-back block row (pixels)
//  plane        out  2       0=Y 1=U 2=V of write-back block
//  busy         out  1       high in every state except IDLE
//  finish       out  1       1-cycle pulse at end of frame
//  proto_err    out  1       sticky: finish pulse received for a stage not running
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, flags/counters cleared; reset mid-frame aborts immediately.
//  TOTAL = Y_W_BLK*Y_H_BLK + 2*C_W_BLK*C_H_BLK blocks; blk_cnt counts CT completions.
//  States/phase: IDLE0 LEADIN_F1 LEADIN_T2 COMMON_SF3 COMMON_TW4 LEADOUT_S5 LEADOUT_W6 DONE7.
//  IDLE: start -> fetch_start=1, ->LEADIN_F.  LEADIN_F: fetch_finish -> ct_start, ->LEADIN_T.
//  LEADIN_T: ct_finish -> cs_start+fetch_start same cycle, ->COMMON_SF.
//  COMMON_SF: cs_finish sets cs_flag, fetch_finish sets f_flag (same-cycle arrival legal);
//   when both flags set (registered) -> clear flags, ct_start+ws_start, ->COMMON_TW.
//  COMMON_TW: ct_finish -> blk_cnt++; if blk_cnt==TOTAL-1 (pre-inc) cs_start, ->LEADOUT_S;
//   else cs_start+fetch_start, ->COMMON_SF. ws_finish inside COMMON_TW/SF is accepted silently.
//  LEADOUT_S: cs_finish -> ws_start, ->LEADOUT_W.  LEADOUT_W: ws_finish -> DONE.
//  DONE: finish=1 one cycle, ->IDLE. start while busy ignored.
//  Address advance on each ct_finish in COMMON_TW (after the ws_start it accompanies):
//   col += BLK/2; if col == (W_BLK-1)*BLK/2 (W per plane) col=0, row += BLK;
//   if also row == (H_BLK-1)*BLK: row=0, plane++ (Y->U->V). No wrap past V.
//  Stage timing unconstrained: any latency >=1 cycle for each stage is tolerated.
//  Finish pulse for a stage not started/outstanding -> proto_err=1 (cleared only by reset), state unaffected.
// CONFIGURATION
//  SEQ_STALL_CNT_EN defined: extra port stall_cycles out 20 = cycles spent in COMMON_SF with
//   exactly one of cs_flag/f_flag set; cleared on start; saturates at all-ones.
//  Undefined: port absent, no counter logic.
// TESTING
//  Params Y_W=2 Y_H=2 C_W=1 C_H=2, stages echo finish after 3 cycles: start -> finish pulse after 8 CT blocks; 8 ws_start, 8 ct_start total.
//  Same params: (col,row,plane) at successive ws_start = (0,0,0)(4,0,0)(0,8,0)(4,8,0)(0,0,1)(0,8,1)(0,0,2)(0,8,2).
//  cs_finish and fetch_finish in same cycle in COMMON_SF -> ct_start+ws_start exactly 2 cycles later.
//  fetch_finish 20 cycles after cs_finish -> no ct_start before it; with SEQ_STALL_CNT_EN stall_cycles ~=20.
//  ct_finish pulsed in IDLE -> proto_err=1, busy stays 0; start pulsed while busy -> no extra fetch_start.
//  Resetn low mid COMMON_TW -> all outputs 0 asynchronously; next start runs full frame from (0,0,0).

Source files
------------

// File: rtl/m2_block_sequencer.sv
// m2_block_sequencer
//   Frame-level scheduler for the IDCT milestone pipeline. Issues start pulses
//   to the fetch-Sp, compute-T, compute-S and write-S stages and collects their
//   finish pulses. Fetch+CS of one block overlap CT+WS of the neighbouring one.
//   Generates write-back block coordinates for the Y, U and V planes.
//
// Ports
//   Clock_50, Resetn (async, active-low)
//   start                  begin a frame (ignored while busy)
//   fetch_/ct_/cs_/ws_start  1-cycle start pulses to the stages
//   fetch_/ct_/cs_/ws_finish 1-cycle finish pulses from the stages
//   phase                  state code, used as the port-ownership mux select
//   col_addr/row_addr/plane  write-back coordinates of the current write-S block
//   busy                   high outside IDLE
//   finish                 1-cycle end-of-frame pulse
//   proto_err              sticky: finish received for a stage not running
//   stall_cycles           (only with SEQ_STALL_CNT_EN) cycles in COMMON_SF
//                          waiting on exactly one of the two finishes
//
// Build option: define SEQ_STALL_CNT_EN to add the stall_cycles counter.

module m2_block_sequencer #(
  parameter int unsigned Y_W_BLK = 40,
  parameter int unsigned Y_H_BLK = 30,
  parameter int unsigned C_W_BLK = 20,
  parameter int unsigned C_H_BLK = 30,
  parameter int unsigned BLK     = 8,
  parameter int unsigned ADDR_W  = 10
) (
  input  logic              Clock_50,
  input  logic              Resetn,
  input  logic              start,
  output logic              fetch_start,
  input  logic              fetch_finish,
  output logic              ct_start,
  input  logic              ct_finish,
  output logic              cs_start,
  input  logic              cs_finish,
  output logic              ws_start,
  input  logic              ws_finish,
  output logic [2:0]        phase,
  output logic [ADDR_W-1:0] col_addr,
  output logic [ADDR_W-1:0] row_addr,
  output logic [1:0]        plane,
  output logic              busy,
  output logic              finish,
  output logic              proto_err
`ifdef SEQ_STALL_CNT_EN
  ,
  output logic [19:0]       stall_cycles
`endif
);

  localparam int unsigned TOTAL = Y_W_BLK * Y_H_BLK + 2 * C_W_BLK * C_H_BLK;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);

  localparam logic [CNT_W-1:0]  LAST_BLK   = CNT_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] COL_STEP   = ADDR_W'(BLK / 2);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(BLK);
  localparam logic [ADDR_W-1:0] Y_LAST_COL = ADDR_W'((Y_W_BLK - 1) * BLK / 2);
  localparam logic [ADDR_W-1:0] Y_LAST_ROW = ADDR_W'((Y_H_BLK - 1) * BLK);
  localparam logic [ADDR_W-1:0] C_LAST_COL = ADDR_W'((C_W_BLK - 1) * BLK / 2);
  localparam logic [ADDR_W-1:0] C_LAST_ROW = ADDR_W'((C_H_BLK - 1) * BLK);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LEADIN_F  = 3'd1,
    S_LEADIN_T  = 3'd2,
    S_COMMON_SF = 3'd3,
    S_COMMON_TW = 3'd4,
    S_LEADOUT_S = 3'd5,
    S_LEADOUT_W = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t            state, state_n;
  logic              fetch_start_n, ct_start_n, cs_start_n, ws_start_n, finish_n;
  logic              cs_flag, f_flag, cs_flag_n, f_flag_n;
  logic              blk_inc, adv, clr;
  logic [CNT_W-1:0]  blk_cnt;
  logic [ADDR_W-1:0] col_n, row_n;
  logic [1:0]        plane_n;

  // Outstanding-work tracking. Write-S may still be running when the next one
  // is issued, so it gets a small counter instead of a single bit.
  logic              f_out, t_out, s_out;
  logic [1:0]        w_cnt, w_cnt_n;
  logic              f_ok, t_ok, s_ok, w_ok, proto_set;

  assign f_ok = fetch_finish & f_out;
  assign t_ok = ct_finish & t_out;
  assign s_ok = cs_finish & s_out;
  assign w_ok = ws_finish & (w_cnt != 2'd0);

  assign proto_set = (fetch_finish & ~f_out) | (ct_finish & ~t_out) |
                     (cs_finish & ~s_out) | (ws_finish & (w_cnt == 2'd0));

  assign phase = state;
  assign busy  = (state != S_IDLE);

  always_comb begin
    state_n       = state;
    fetch_start_n = 1'b0;
    ct_start_n    = 1'b0;
    cs_start_n    = 1'b0;
    ws_start_n    = 1'b0;
    finish_n      = 1'b0;
    cs_flag_n     = cs_flag;
    f_flag_n      = f_flag;
    blk_inc       = 1'b0;
    adv           = 1'b0;
    clr           = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          clr           = 1'b1;
          fetch_start_n = 1'b1;
          state_n       = S_LEADIN_F;
        end
      end
      S_LEADIN_F: begin
        if (f_ok) begin
          ct_start_n = 1'b1;
          state_n    = S_LEADIN_T;
        end
      end
      S_LEADIN_T: begin
        // The lead-in CT completion counts toward blk_cnt.
        if (t_ok) begin
          blk_inc       = 1'b1;
          cs_start_n    = 1'b1;
          fetch_start_n = 1'b1;
          state_n       = S_COMMON_SF;
        end
      end
      S_COMMON_SF: begin
        if (cs_flag && f_flag) begin
          cs_flag_n  = 1'b0;
          f_flag_n   = 1'b0;
          ct_start_n = 1'b1;
          ws_start_n = 1'b1;
          state_n    = S_COMMON_TW;
        end else begin
          if (s_ok) cs_flag_n = 1'b1;
          if (f_ok) f_flag_n  = 1'b1;
        end
      end
      S_COMMON_TW: begin
        if (t_ok) begin
          blk_inc    = 1'b1;
          adv        = 1'b1;
          cs_start_n = 1'b1;
          if (blk_cnt == LAST_BLK) begin
            state_n = S_LEADOUT_S;
          end else begin
            fetch_start_n = 1'b1;
            state_n       = S_COMMON_SF;
          end
        end
      end
      S_LEADOUT_S: begin
        if (s_ok) begin
          ws_start_n = 1'b1;
          state_n    = S_LEADOUT_W;
        end
      end
      S_LEADOUT_W: begin
        // Only the final write-S completion ends the frame.
        if (w_ok && (w_cnt == 2'd1)) begin
          finish_n = 1'b1;
          state_n  = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_cnt_n = w_cnt;
    if (w_ok && !ws_start_n) begin
      w_cnt_n = w_cnt - 2'd1;
    end else if (!w_ok && ws_start_n && (w_cnt != 2'd3)) begin
      w_cnt_n = w_cnt + 2'd1;
    end
  end

  // Raster order within a plane, then Y -> U -> V; plane saturates at V.
  always_comb begin
    col_n   = col_addr;
    row_n   = row_addr;
    plane_n = plane;
    if (clr) begin
      col_n   = '0;
      row_n   = '0;
      plane_n = '0;
    end else if (adv) begin
      if (col_addr == ((plane == 2'd0) ? Y_LAST_COL : C_LAST_COL)) begin
        col_n = '0;
        if (row_addr == ((plane == 2'd0) ? Y_LAST_ROW : C_LAST_ROW)) begin
          row_n = '0;
          if (plane != 2'd2) plane_n = plane + 2'd1;
        end else begin
          row_n = row_addr + ROW_STEP;
        end
      end else begin
        col_n = col_addr + COL_STEP;
      end
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state       <= S_IDLE;
      fetch_start <= 1'b0;
      ct_start    <= 1'b0;
      cs_start    <= 1'b0;
      ws_start    <= 1'b0;
      finish      <= 1'b0;
      proto_err   <= 1'b0;
      cs_flag     <= 1'b0;
      f_flag      <= 1'b0;
      blk_cnt     <= '0;
      col_addr    <= '0;
      row_addr    <= '0;
      plane       <= '0;
      f_out       <= 1'b0;
      t_out       <= 1'b0;
      s_out       <= 1'b0;
      w_cnt       <= '0;
    end else begin
      state       <= state_n;
      fetch_start <= fetch_start_n;
      ct_start    <= ct_start_n;
      cs_start    <= cs_start_n;
      ws_start    <= ws_start_n;
      finish      <= finish_n;
      cs_flag     <= cs_flag_n;
      f_flag      <= f_flag_n;
      col_addr    <= col_n;
      row_addr    <= row_n;
      plane       <= plane_n;
      f_out       <= fetch_start_n | (f_out & ~fetch_finish);
      t_out       <= ct_start_n | (t_out & ~ct_finish);
      s_out       <= cs_start_n | (s_out & ~cs_finish);
      w_cnt       <= w_cnt_n;
      if (proto_set) proto_err <= 1'b1;
      if (clr) begin
        blk_cnt <= '0;
      end else if (blk_inc) begin
        blk_cnt <= blk_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SEQ_STALL_CNT_EN
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      stall_cycles <= '0;
    end else if (clr) begin
      stall_cycles <= '0;
    end else if ((state == S_COMMON_SF) && (cs_flag ^ f_flag) &&
                 (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 20'd1;
    end
  end
`endif

endmodule

// File: tb/tb_m2_block_sequencer.sv
// tb_m2_block_sequencer
//   Self-checking bench for m2_block_sequencer with a small frame
//   (Y 2x2 blocks, U/V 1x2 blocks, 8 blocks total). Stage models echo finish
//   pulses after fixed or random latency; the expected write-back coordinates
//   and issue timing are derived from the frame geometry.

`timescale 1ns/1ps

module tb_m2_block_sequencer;

  localparam int YW    = 2;
  localparam int YH    = 2;
  localparam int CW    = 1;
  localparam int CH    = 2;
  localparam int BLKP  = 8;
  localparam int AW    = 10;
  localparam int TOTAL = YW * YH + 2 * CW * CH;

  logic          Clock_50 = 1'b0;
  logic          Resetn   = 1'b0;
  logic          start    = 1'b0;
  logic          fetch_start, ct_start, cs_start, ws_start;
  logic          fetch_finish, ct_finish, cs_finish, ws_finish;
  logic [2:0]    phase;
  logic [AW-1:0] col_addr, row_addr;
  logic [1:0]    plane;
  logic          busy, finish, proto_err;
`ifdef SEQ_STALL_CNT_EN
  logic [19:0]   stall_cycles;
`endif

  logic f_fin_m = 1'b0, t_fin_m = 1'b0, s_fin_m = 1'b0, w_fin_m = 1'b0;
  logic inj_ct = 1'b0;

  assign fetch_finish = f_fin_m;
  assign ct_finish    = t_fin_m | inj_ct;
  assign cs_finish    = s_fin_m;
  assign ws_finish    = w_fin_m;

  m2_block_sequencer #(
    .Y_W_BLK(YW), .Y_H_BLK(YH), .C_W_BLK(CW), .C_H_BLK(CH),
    .BLK(BLKP), .ADDR_W(AW)
  ) dut (
    .Clock_50    (Clock_50),
    .Resetn      (Resetn),
    .start       (start),
    .fetch_start (fetch_start),
    .fetch_finish(fetch_finish),
    .ct_start    (ct_start),
    .ct_finish   (ct_finish),
    .cs_start    (cs_start),
    .cs_finish   (cs_finish),
    .ws_start    (ws_start),
    .ws_finish   (ws_finish),
    .phase       (phase),
    .col_addr    (col_addr),
    .row_addr    (row_addr),
    .plane       (plane),
    .busy        (busy),
    .finish      (finish),
    .proto_err   (proto_err)
`ifdef SEQ_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 Clock_50 = ~Clock_50;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int cnt_fs, cnt_ct, cnt_cs, cnt_ws, cnt_fin;
  int last_cs = 0, last_f = 0;
  int pf = 0, pt = 0, ps = 0, pw = 0;
  int lat_f = 3, lat_t = 3, lat_s = 3, lat_w = 3;
  bit rnd = 1'b0;
  int exp_stall = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Write-back coordinates of the idx-th block in frame order.
  function automatic void exp_addr(input int idx, output int c, output int r, output int p);
    int k;
    k = 0; c = 0; r = 0; p = 0;
    for (int pl = 0; pl < 3; pl++) begin
      for (int rr = 0; rr < ((pl == 0) ? YH : CH); rr++) begin
        for (int cc = 0; cc < ((pl == 0) ? YW : CW); cc++) begin
          if (k == idx) begin
            c = cc * BLKP / 2;
            r = rr * BLKP;
            p = pl;
          end
          k++;
        end
      end
    end
  endfunction

  // One clock: observe DUT outputs at the negedge, then drive stage finishes.
  task automatic tick();
    int c, r, p, d;
    @(negedge Clock_50);
    cyc++;
    if (Resetn) begin
      if (fetch_start) cnt_fs++;
      if (cs_start)    cnt_cs++;
      if (ws_start) begin
        exp_addr(cnt_ws, c, r, p);
        check("ws_col",   int'(col_addr), c);
        check("ws_row",   int'(row_addr), r);
        check("ws_plane", int'(plane),    p);
        cnt_ws++;
      end
      if (ct_start) begin
        cnt_ct++;
        if (phase == 3'd4) begin
          // Steady-state CT issue: two cycles after the later of CS/fetch done.
          d = (last_cs > last_f) ? last_cs : last_f;
          check("ct_issue_delay", cyc - d, 2);
          exp_stall += (last_cs > last_f) ? (last_cs - last_f) : (last_f - last_cs);
        end
      end
      if (finish) begin
        cnt_fin++;
        check("finish_phase", int'(phase), 7);
      end
    end
    f_fin_m = 1'b0; t_fin_m = 1'b0; s_fin_m = 1'b0; w_fin_m = 1'b0;
    if (!Resetn) begin
      pf = 0; pt = 0; ps = 0; pw = 0;
    end else begin
      if (pf > 0) begin pf--; if (pf == 0) begin f_fin_m = 1'b1; last_f  = cyc; end end
      if (pt > 0) begin pt--; if (pt == 0) t_fin_m = 1'b1; end
      if (ps > 0) begin ps--; if (ps == 0) begin s_fin_m = 1'b1; last_cs = cyc; end end
      if (pw > 0) begin pw--; if (pw == 0) w_fin_m = 1'b1; end
      if (fetch_start) pf = rnd ? int'($urandom_range(1, 6)) : lat_f;
      if (ct_start)    pt = rnd ? int'($urandom_range(1, 6)) : lat_t;
      if (cs_start)    ps = rnd ? int'($urandom_range(1, 6)) : lat_s;
      if (ws_start)    pw = rnd ? int'($urandom_range(1, 3)) : lat_w;
    end
  endtask

  task automatic run_frame(input bit poke);
    int budget;
    cnt_fs = 0; cnt_ct = 0; cnt_cs = 0; cnt_ws = 0; cnt_fin = 0; exp_stall = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (poke) begin
      repeat (10) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    budget = 0;
    while (cnt_fin == 0 && budget < 3000) begin
      tick();
      budget++;
    end
    check("frame_done_in_budget", int'(cnt_fin != 0), 1);
    repeat (3) tick();
    check("finish_pulses", cnt_fin, 1);
    check("ct_start_count", cnt_ct, TOTAL);
    check("ws_start_count", cnt_ws, TOTAL);
    check("fetch_start_count", cnt_fs, TOTAL);
    check("cs_start_count", cnt_cs, TOTAL);
    check("busy_after_frame", int'(busy), 0);
    check("phase_after_frame", int'(phase), 0);
    check("proto_err_clean", int'(proto_err), 0);
`ifdef SEQ_STALL_CNT_EN
    check("stall_cycles", int'(stall_cycles), exp_stall);
`endif
  endtask

  initial begin
    int budget;
    Resetn = 1'b0;
    repeat (3) tick();
    check("rst_phase", int'(phase), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pulses", int'({fetch_start, ct_start, cs_start, ws_start, finish}), 0);
    check("rst_addr", int'({col_addr, row_addr, plane}), 0);
    check("rst_proto", int'(proto_err), 0);
    Resetn = 1'b1;
    tick();

    // Fixed 3-cycle stages.
    run_frame(1'b0);

    // Random latencies, with start pokes while busy.
    rnd = 1'b1;
    run_frame(1'b1);
    run_frame(1'b0);
    run_frame(1'b1);

    // CS and fetch finish in the same cycle.
    rnd = 1'b0;
    lat_f = 2; lat_s = 2; lat_t = 1; lat_w = 1;
    run_frame(1'b0);

    // Fetch finishes 20 cycles after CS.
    lat_f = 22;
    run_frame(1'b0);

    // Stray ct_finish while idle.
    inj_ct = 1'b1;
    tick();
    inj_ct = 1'b0;
    tick();
    check("proto_err_set", int'(proto_err), 1);
    check("proto_busy", int'(busy), 0);
    check("proto_phase", int'(phase), 0);

    // Reset asserted mid COMMON_TW.
    lat_f = 3; lat_t = 3; lat_s = 3; lat_w = 3;
    cnt_ws = 0; cnt_fs = 0; cnt_ct = 0; cnt_cs = 0; cnt_fin = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    budget = 0;
    while (phase != 3'd4 && budget < 200) begin
      tick();
      budget++;
    end
    check("reach_common_tw", int'(phase), 4);
    #2 Resetn = 1'b0;
    #1;
    check("arst_phase", int'(phase), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_pulses", int'({fetch_start, ct_start, cs_start, ws_start, finish}), 0);
    check("arst_addr", int'({col_addr, row_addr, plane}), 0);
    check("arst_proto", int'(proto_err), 0);
    tick();
    Resetn = 1'b1;
    tick();
    run_frame(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
